// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch check, 2-bit BHT update, mispredict flush/redirect; optional BRANCH_STATS_EN
module branch_resolver #(
    parameter int DATA_WIDTH = 32,
    parameter int BHT_IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  if_pred_taken,
    input  logic                  ex_branch,
    input  logic                  ex_stall,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_pred_target,
    input  logic                  ex_taken,
    input  logic [DATA_WIDTH-1:0] ex_target,
    output logic                  flush_out,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int BHT_SIZE = 1 << BHT_IDX_W;

    logic [1:0]            bht [BHT_SIZE];
    logic [BHT_IDX_W-1:0]  if_idx;
    logic [BHT_IDX_W-1:0]  ex_idx;
    logic [1:0]            bht_cur;
    logic [1:0]            bht_next;
    logic                  resolve;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] seq_pc;
    logic [DATA_WIDTH-1:0] fix_pc;
    logic                  unused_bits;

    assign if_idx  = if_pc[BHT_IDX_W+1:2];
    assign ex_idx  = ex_pc[BHT_IDX_W+1:2];
    assign bht_cur = bht[ex_idx];

    // Lookup reads the stored counter only; an update in the same cycle is not forwarded.
    assign if_pred_taken = bht[if_idx][1];

    // A branch in EX while a flush is out is on the wrong path and must be squashed.
    assign resolve = ex_branch & ~ex_stall & ~flush_out;

    // Fall-through PC ignores the byte-offset bits and wraps naturally.
    assign seq_pc = {ex_pc[DATA_WIDTH-1:2], 2'b00} + DATA_WIDTH'(4);

    assign redirect_valid = flush_out;

    assign unused_bits = ^{if_pc[DATA_WIDTH-1:BHT_IDX_W+2], if_pc[1:0], ex_pc[1:0]};

    // Classify the prediction and choose the corrective fetch address.
    always_comb begin
        mispredict = 1'b0;
        fix_pc     = ex_target;
        if (ex_pred_taken && !ex_taken) begin
            mispredict = 1'b1;
            fix_pc     = seq_pc;
        end else if (!ex_pred_taken && ex_taken) begin
            mispredict = 1'b1;
        end else if (ex_pred_taken && ex_taken && (ex_pred_target != ex_target)) begin
            mispredict = 1'b1;
        end
    end

    // Saturating step of the resolved branch's counter.
    always_comb begin
        bht_next = bht_cur;
        if (ex_taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
        end
    end

    // One-cycle flush and redirect register; redirect_pc keeps its last value between flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_out   <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush_out <= resolve & mispredict;
            if (resolve && mispredict) redirect_pc <= fix_pc;
        end
    end

    // Predictor table: every resolved branch trains its entry, right or wrong.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            bht[ex_idx] <= bht_next;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating event counters for resolves and mispredicts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (resolve) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - table-driven bench for branch_resolver
module tb_branch_resolver;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_branch;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolver #(.DATA_WIDTH(32), .BHT_IDX_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_branch      (ex_branch),
        .ex_stall       (ex_stall),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .flush_out      (flush_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] ptgt;
        logic        taken;
        logic [31:0] tgt;
        logic        exp_flush;
        logic [31:0] exp_rpc;
        logic        exp_pred;
    } vec_t;

    vec_t        vecs[11];
    int          tests;
    int          fails;
    logic [31:0] last_rpc;
`ifdef BRANCH_STATS_EN
    logic [31:0] sb0;
    logic [31:0] sm0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic pred, input logic [31:0] ptgt,
                            input logic taken, input logic [31:0] tgt);
        ex_branch      = 1'b1;
        ex_pc          = pc;
        ex_pred_taken  = pred;
        ex_pred_target = ptgt;
        ex_taken       = taken;
        ex_target      = tgt;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_rpc = 32'h0;
        //         pc            pred ptgt          taken tgt          flush rpc           pred_after
        vecs[0]  = '{32'h0000_0040, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1};
        vecs[1]  = '{32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0};
        vecs[2]  = '{32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b1};
        vecs[3]  = '{32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b1};
        vecs[4]  = '{32'h0000_0040, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b1};
        vecs[5]  = '{32'h0000_0040, 1'b1, 32'h0000_0084, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFC, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'h0000_0004, 1'b0, 32'h0,         1'b0, 32'h0000_0900, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{32'h0000_000B, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_000C, 1'b0};
        vecs[9]  = '{32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_0044, 1'b1};
        vecs[10] = '{32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h0000_0080, 1'b0, 32'h0,         1'b0};

        reset = 1'b0;
        if_pc = 32'h0;
        ex_branch = 1'b0;
        ex_stall = 1'b0;
        ex_pc = 32'h0;
        ex_pred_taken = 1'b0;
        ex_pred_target = 32'h0;
        ex_taken = 1'b0;
        ex_target = 32'h0;
        repeat (3) tick();
        chk("reset_flush", {31'b0, flush_out}, 32'h0);
        chk("reset_rpc", redirect_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Reset sweep of every predictor entry.
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            chk($sformatf("reset_pred[%0d]", i), {31'b0, if_pred_taken}, 32'h0);
        end
        chk("reset_rv", {31'b0, redirect_valid}, 32'h0);
        chk("reset_rpc2", redirect_pc, 32'h0);
`ifdef BRANCH_STATS_EN
        chk("reset_stat_b", stat_branches, 32'h0);
        chk("reset_stat_m", stat_mispredicts, 32'h0);
`endif

        // Table-driven single-branch vectors.
        for (int v = 0; v < 11; v++) begin
            drive_br(vecs[v].pc, vecs[v].pred, vecs[v].ptgt, vecs[v].taken, vecs[v].tgt);
            tick();
            ex_branch = 1'b0;
            if (vecs[v].exp_flush) last_rpc = vecs[v].exp_rpc;
            chk($sformatf("v%0d_flush", v), {31'b0, flush_out}, {31'b0, vecs[v].exp_flush});
            chk($sformatf("v%0d_rv", v), {31'b0, redirect_valid}, {31'b0, vecs[v].exp_flush});
            chk($sformatf("v%0d_rpc", v), redirect_pc, last_rpc);
            tick();
            chk($sformatf("v%0d_flush_clr", v), {31'b0, flush_out}, 32'h0);
            chk($sformatf("v%0d_rpc_hold", v), redirect_pc, last_rpc);
            if_pc = vecs[v].pc;
            #1;
            chk($sformatf("v%0d_pred", v), {31'b0, if_pred_taken}, {31'b0, vecs[v].exp_pred});
        end

        // Back-to-back: wrong-path branch right after a mispredict is squashed.
        drive_br(32'h20, 1'b0, 32'h0, 1'b1, 32'h500);
        tick();
        chk("b2b_flush1", {31'b0, flush_out}, 32'h1);
        chk("b2b_rpc1", redirect_pc, 32'h500);
        drive_br(32'h24, 1'b0, 32'h0, 1'b1, 32'h600);
        tick();
        ex_branch = 1'b0;
        chk("b2b_noflush2", {31'b0, flush_out}, 32'h0);
        chk("b2b_rpc_hold", redirect_pc, 32'h500);
        if_pc = 32'h24;
        #1;
        chk("b2b_bht_second", {31'b0, if_pred_taken}, 32'h0);
        if_pc = 32'h20;
        #1;
        chk("b2b_bht_first", {31'b0, if_pred_taken}, 32'h1);

        // Stalled mispredicting branch resolves once.
`ifdef BRANCH_STATS_EN
        sb0 = stat_branches;
        sm0 = stat_mispredicts;
`endif
        drive_br(32'h30, 1'b0, 32'h0, 1'b1, 32'h700);
        ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_noflush%0d", c), {31'b0, flush_out}, 32'h0);
        end
        ex_stall = 1'b0;
        tick();
        ex_branch = 1'b0;
        chk("stall_flush", {31'b0, flush_out}, 32'h1);
        chk("stall_rpc", redirect_pc, 32'h700);
        tick();
        chk("stall_flush_clr", {31'b0, flush_out}, 32'h0);
`ifdef BRANCH_STATS_EN
        chk("stall_stat_b", stat_branches, sb0 + 32'd1);
        chk("stall_stat_m", stat_mispredicts, sm0 + 32'd1);
`endif
        if_pc = 32'h30;
        #1;
        chk("stall_bht_step", {31'b0, if_pred_taken}, 32'h1);
        drive_br(32'h30, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        ex_branch = 1'b0;
        chk("stall_nt_noflush", {31'b0, flush_out}, 32'h0);
        chk("stall_bht_single", {31'b0, if_pred_taken}, 32'h0);

        // Same-index lookup during update returns the old counter.
        if_pc = 32'h50;
        drive_br(32'h50, 1'b1, 32'h90, 1'b1, 32'h90);
        #1;
        chk("nobypass_before", {31'b0, if_pred_taken}, 32'h0);
        tick();
        ex_branch = 1'b0;
        chk("nobypass_after", {31'b0, if_pred_taken}, 32'h1);
        chk("nobypass_noflush", {31'b0, flush_out}, 32'h0);

        // Asynchronous reset in the middle of a flush.
        drive_br(32'h40, 1'b0, 32'h0, 1'b1, 32'hA00);
        tick();
        ex_branch = 1'b0;
        chk("areset_pre_flush", {31'b0, flush_out}, 32'h1);
        reset = 1'b0;
        #1;
        chk("areset_flush", {31'b0, flush_out}, 32'h0);
        chk("areset_rv", {31'b0, redirect_valid}, 32'h0);
        chk("areset_rpc", redirect_pc, 32'h0);
        if_pc = 32'h40;
        #1;
        chk("areset_bht", {31'b0, if_pred_taken}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_reset_flush", {31'b0, flush_out}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
